// File: rtl/word_game_ctrl.sv
// Word-scramble game sequencer: login, difficulty, timed play, swaps, saturating score, paged top scores.
// Define BEST_SCORE_EN to keep a per-mode best-score table and drive best_score/new_best.
module word_game_ctrl #(
  parameter  int NUM_MODES = 3,
  parameter  int SCORE_W   = 7,
  parameter  int IDX_W     = 3,
  parameter  int PID_W     = 3,
  localparam int MW        = (NUM_MODES > 1) ? $clog2(NUM_MODES) : 1
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               log_on,
  input  logic               pwd_pls,
  input  logic               start_pls,
  input  logic               load_pls,
  input  logic               is_correct,
  input  logic               time_out,
  input  logic [PID_W-1:0]   pid_in,
  input  logic               is_guest_in,
  input  logic [IDX_W-1:0]   ind_in1,
  input  logic [IDX_W-1:0]   ind_in2,
  output logic [2:0]         control_sig,
  output logic               mux_ctrl,
  output logic               log_out,
  output logic [MW-1:0]      mode,
  output logic [3:0]         mode_disp,
  output logic               scram_pls,
  output logic               flip_pls,
  output logic [IDX_W-1:0]   ind_out1,
  output logic [IDX_W-1:0]   ind_out2,
  output logic               timer_en,
  output logic               timer_reconfig,
  output logic [SCORE_W-1:0] score,
  output logic [SCORE_W-1:0] best_score,
  output logic               new_best,
  output logic [PID_W-1:0]   pid_out,
  output logic               is_guest_out
);

  localparam logic [2:0] IDLE     = 3'd0;
  localparam logic [2:0] SETUP    = 3'd1;
  localparam logic [2:0] GETWORD  = 3'd2;
  localparam logic [2:0] SWAP     = 3'd3;
  localparam logic [2:0] CORRECT  = 3'd4;
  localparam logic [2:0] GAMEOVER = 3'd5;
  localparam logic [2:0] LOGOUT   = 3'd6;
  localparam logic [2:0] TOPSCORE = 3'd7;

  localparam logic [MW-1:0]      LAST_MODE = MW'(NUM_MODES - 1);
  localparam logic [SCORE_W-1:0] SCORE_MAX = '1;

  logic [2:0]    state;
  logic [2:0]    nextState;
  logic [MW-1:0] nextMode;
  logic          page;
  logic          nextPage;
  logic [2:0]    nextCtrl;
  logic          enterGameover;

  // Outputs are registered from the next state, so each response lands on the
  // same edge as the state change it belongs to.
  always_comb begin
    // NOTE: every always_comb output gets a default first so no path infers a latch.
    nextState = state;
    nextMode  = mode;
    nextPage  = page;
    case (state)
      IDLE:     if (log_on) nextState = SETUP;
      SETUP: begin
        if (start_pls)     nextState = GETWORD;
        else if (pwd_pls)  nextState = LOGOUT;
        else if (load_pls) begin
          if (mode == LAST_MODE) begin
            nextMode  = '0;
            nextPage  = 1'b0;
            nextState = TOPSCORE;
          end else begin
            nextMode = mode + MW'(1);
          end
        end
      end
      GETWORD: begin
        if (start_pls)     nextState = IDLE;
        else if (time_out) nextState = GAMEOVER;
        else if (pwd_pls)  nextState = SWAP;
      end
      SWAP: begin
        if (start_pls)       nextState = IDLE;
        else if (time_out)   nextState = GAMEOVER;
        else if (is_correct) nextState = CORRECT;
      end
      CORRECT:  nextState = GETWORD;
      GAMEOVER: if (start_pls) nextState = IDLE;
      LOGOUT:   nextState = IDLE;
      TOPSCORE: begin
        if (start_pls)     nextPage  = ~page;
        else if (load_pls) nextState = IDLE;
      end
      default:  nextState = IDLE;
    endcase
    if (nextState == IDLE) nextMode = '0;
  end

  always_comb begin
    nextCtrl = 3'd0;
    case (nextState)
      SETUP, LOGOUT:          nextCtrl = 3'd1;
      GETWORD, SWAP, CORRECT: nextCtrl = 3'd2;
      GAMEOVER:               nextCtrl = 3'd3;
      TOPSCORE:               nextCtrl = {2'b10, nextPage};
      default:                nextCtrl = 3'd0;
    endcase
  end

  assign enterGameover = (nextState == GAMEOVER) && (state != GAMEOVER);

  // NOTE: sequential state uses non-blocking assignments only, so every register
  // samples the pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state          <= IDLE;
      page           <= 1'b0;
      control_sig    <= 3'd0;
      mux_ctrl       <= 1'b0;
      log_out        <= 1'b0;
      mode           <= '0;
      mode_disp      <= 4'd0;
      scram_pls      <= 1'b0;
      flip_pls       <= 1'b0;
      ind_out1       <= '0;
      ind_out2       <= '0;
      timer_en       <= 1'b0;
      timer_reconfig <= 1'b0;
      score          <= '0;
      pid_out        <= '0;
      is_guest_out   <= 1'b0;
    end else begin
      state          <= nextState;
      page           <= nextPage;
      mode           <= nextMode;
      mode_disp      <= 4'(nextMode) + 4'd4;
      control_sig    <= nextCtrl;
      timer_en       <= nextState inside {GETWORD, SWAP, CORRECT};
      timer_reconfig <= (state == SETUP) && (nextState == GETWORD);
      scram_pls      <= (state == GETWORD) && (nextState == SWAP);
      flip_pls       <= (state == SWAP) && (nextState == SWAP) && load_pls;
      log_out        <= (state == SETUP) && (nextState == LOGOUT);

      if ((state == IDLE) && (nextState == SETUP)) mux_ctrl <= 1'b1;
      else if (state == LOGOUT)                    mux_ctrl <= 1'b0;

      if (state == SWAP) begin
        ind_out1 <= ind_in1;
        ind_out2 <= ind_in2;
      end

      // A solved word and an expiring timer in the same cycle never reach CORRECT.
      if (nextState == SETUP)
        score <= '0;
      else if ((nextState == CORRECT) && (score != SCORE_MAX))
        score <= score + SCORE_W'(1);

      if (enterGameover) begin
        pid_out      <= pid_in;
        is_guest_out <= is_guest_in;
      end
    end
  end

`ifdef BEST_SCORE_EN
  logic [SCORE_W-1:0] bestTbl [NUM_MODES];
  logic               bestWr;

  assign bestWr = enterGameover && !is_guest_in && (score > bestTbl[mode]);

  always_ff @(posedge clk) begin
    if (!rst) begin
      // NOTE: the table is small and must read as zero after reset, so it is
      // built from resettable flops rather than an uninitialised RAM.
      for (int i = 0; i < NUM_MODES; i++) bestTbl[i] <= '0;
      best_score <= '0;
      new_best   <= 1'b0;
    end else begin
      if (bestWr) bestTbl[mode] <= score;
      best_score <= (bestWr && (nextMode == mode)) ? score : bestTbl[nextMode];
      if (enterGameover)          new_best <= bestWr;
      else if (nextState == IDLE) new_best <= 1'b0;
    end
  end
`else
  assign best_score = '0;
  assign new_best   = 1'b0;
`endif

endmodule

// File: tb/tb_word_game_ctrl.sv
// Self-checking bench for word_game_ctrl: directed scenarios plus randomized play,
// every output compared each cycle against a transaction-level game model.
module tb_word_game_ctrl;

  localparam int NUM_MODES = 3;
  localparam int SCORE_W   = 2;
  localparam int IDX_W     = 3;
  localparam int PID_W     = 3;
  localparam int MW        = 2;
  localparam int SCORE_MAX = (1 << SCORE_W) - 1;

`ifdef BEST_SCORE_EN
  localparam bit BEST_EN = 1'b1;
`else
  localparam bit BEST_EN = 1'b0;
`endif

  // command bits: {log_on, pwd, start, load, correct, time_out}
  localparam logic [5:0] C_NONE  = 6'b000000;
  localparam logic [5:0] C_LOG   = 6'b100000;
  localparam logic [5:0] C_PWD   = 6'b010000;
  localparam logic [5:0] C_START = 6'b001000;
  localparam logic [5:0] C_LOAD  = 6'b000100;
  localparam logic [5:0] C_CORR  = 6'b000010;
  localparam logic [5:0] C_TOUT  = 6'b000001;

  logic               clk, rst;
  logic               log_on, pwd_pls, start_pls, load_pls, is_correct, time_out;
  logic [PID_W-1:0]   pid_in;
  logic               is_guest_in;
  logic [IDX_W-1:0]   ind_in1, ind_in2;
  logic [2:0]         control_sig;
  logic               mux_ctrl, log_out;
  logic [MW-1:0]      mode;
  logic [3:0]         mode_disp;
  logic               scram_pls, flip_pls;
  logic [IDX_W-1:0]   ind_out1, ind_out2;
  logic               timer_en, timer_reconfig;
  logic [SCORE_W-1:0] score, best_score;
  logic               new_best;
  logic [PID_W-1:0]   pid_out;
  logic               is_guest_out;

  word_game_ctrl #(
    .NUM_MODES(NUM_MODES), .SCORE_W(SCORE_W), .IDX_W(IDX_W), .PID_W(PID_W)
  ) dut (
    .clk(clk), .rst(rst),
    .log_on(log_on), .pwd_pls(pwd_pls), .start_pls(start_pls), .load_pls(load_pls),
    .is_correct(is_correct), .time_out(time_out),
    .pid_in(pid_in), .is_guest_in(is_guest_in), .ind_in1(ind_in1), .ind_in2(ind_in2),
    .control_sig(control_sig), .mux_ctrl(mux_ctrl), .log_out(log_out),
    .mode(mode), .mode_disp(mode_disp), .scram_pls(scram_pls), .flip_pls(flip_pls),
    .ind_out1(ind_out1), .ind_out2(ind_out2),
    .timer_en(timer_en), .timer_reconfig(timer_reconfig),
    .score(score), .best_score(best_score), .new_best(new_best),
    .pid_out(pid_out), .is_guest_out(is_guest_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0d expected %0d at %0t", tag, got, exp, $time);
    end
  endtask

  // ---------------- game model ----------------
  typedef enum {G_IDLE, G_SETUP, G_WAIT_WORD, G_SWAPPING, G_SOLVED, G_OVER, G_LOGOUT, G_TOP} game_t;
  game_t gs;
  int  eMode, eScore, eCtrl, ePage, ePid, eInd1, eInd2, eModeDisp;
  bit  eMux, eLogOut, eScram, eFlip, eTimerEn, eReconf, eNewBest, eGuest;
  int  best [NUM_MODES];

  task automatic modelReset();
    gs = G_IDLE;
    eMode = 0; eScore = 0; eCtrl = 0; ePage = 0; ePid = 0; eInd1 = 0; eInd2 = 0; eModeDisp = 0;
    eMux = 0; eLogOut = 0; eScram = 0; eFlip = 0; eTimerEn = 0; eReconf = 0; eNewBest = 0; eGuest = 0;
    for (int i = 0; i < NUM_MODES; i++) best[i] = 0;
  endtask

  task automatic backToIdle();
    gs = G_IDLE; eCtrl = 0; eTimerEn = 0; eMode = 0; eNewBest = 0;
  endtask

  task automatic endGame();
    gs = G_OVER; eTimerEn = 0; eCtrl = 3;
    ePid = int'(pid_in); eGuest = is_guest_in;
    eNewBest = 0;
    if (BEST_EN && !is_guest_in && eScore > best[eMode]) begin
      best[eMode] = eScore;
      eNewBest = 1;
    end
  endtask

  task automatic modelStep(input logic [5:0] c);
    bit lon, pwd, st, ld, cr, to;
    {lon, pwd, st, ld, cr, to} = c;
    eScram = 0; eFlip = 0; eReconf = 0; eLogOut = 0;
    case (gs)
      G_IDLE: begin
        eMode = 0; eCtrl = 0; eTimerEn = 0;
        if (lon) begin gs = G_SETUP; eMux = 1; eCtrl = 1; eScore = 0; end
      end
      G_SETUP: begin
        if (st) begin gs = G_WAIT_WORD; eTimerEn = 1; eReconf = 1; eCtrl = 2; end
        else if (pwd) begin gs = G_LOGOUT; eLogOut = 1; end
        else if (ld) begin
          if (eMode == NUM_MODES - 1) begin eMode = 0; ePage = 0; gs = G_TOP; eCtrl = 4; end
          else eMode++;
        end
      end
      G_WAIT_WORD: begin
        if (st) backToIdle();
        else if (to) endGame();
        else if (pwd) begin gs = G_SWAPPING; eScram = 1; end
      end
      G_SWAPPING: begin
        eInd1 = int'(ind_in1); eInd2 = int'(ind_in2);
        if (st) backToIdle();
        else if (to) endGame();
        else if (cr) begin gs = G_SOLVED; if (eScore < SCORE_MAX) eScore++; end
        else if (ld) eFlip = 1;
      end
      G_SOLVED: gs = G_WAIT_WORD;
      G_OVER:   if (st) backToIdle();
      G_LOGOUT: begin backToIdle(); eMux = 0; end
      G_TOP: begin
        if (st) begin ePage = 1 - ePage; eCtrl = 4 + ePage; end
        else if (ld) backToIdle();
      end
      default: backToIdle();
    endcase
    eModeDisp = eMode + 4;
  endtask

  task automatic compareAll();
    check("control_sig", control_sig, eCtrl);
    check("mux_ctrl", mux_ctrl, eMux);
    check("log_out", log_out, eLogOut);
    check("mode", mode, eMode);
    check("mode_disp", mode_disp, eModeDisp);
    check("scram_pls", scram_pls, eScram);
    check("flip_pls", flip_pls, eFlip);
    check("ind_out1", ind_out1, eInd1);
    check("ind_out2", ind_out2, eInd2);
    check("timer_en", timer_en, eTimerEn);
    check("timer_reconfig", timer_reconfig, eReconf);
    check("score", score, eScore);
    check("best_score", best_score, BEST_EN ? best[eMode] : 0);
    check("new_best", new_best, eNewBest);
    check("pid_out", pid_out, ePid);
    check("is_guest_out", is_guest_out, eGuest);
  endtask

  bit guestSel = 1'b0;

  // One clock: drive command, let the edge happen, advance the model, compare.
  task automatic cyc(input logic [5:0] c);
    {log_on, pwd_pls, start_pls, load_pls, is_correct, time_out} = c;
    pid_in      = PID_W'($urandom);
    is_guest_in = guestSel;
    ind_in1     = IDX_W'($urandom);
    ind_in2     = IDX_W'($urandom);
    @(posedge clk);
    if (!rst) modelReset();
    else      modelStep(c);
    #1;
    compareAll();
  endtask

  task automatic solveWord();
    cyc(C_PWD);
    cyc(C_CORR);
    cyc(C_NONE);
  endtask

  initial begin
    logic [5:0] c;
    rst = 1'b0;
    {log_on, pwd_pls, start_pls, load_pls, is_correct, time_out} = '0;
    pid_in = '0; is_guest_in = 1'b0; ind_in1 = '0; ind_in2 = '0;
    modelReset();

    repeat (2) cyc(C_NONE);
    check("rst_control_sig", control_sig, 0);
    check("rst_score", score, 0);
    rst = 1'b1;

    // mode stepping and wrap into the top-score pages
    cyc(C_LOG);   check("login_ctrl", control_sig, 1); check("login_mux", mux_ctrl, 1);
    cyc(C_NONE);  check("mode0_disp", mode_disp, 4);
    cyc(C_LOAD);  check("mode1", mode, 1); check("mode1_disp", mode_disp, 5);
    cyc(C_LOAD);  check("mode2", mode, 2); check("mode2_disp", mode_disp, 6);
    cyc(C_LOAD);  check("wrap_ctrl", control_sig, 4); check("wrap_mode", mode, 0);
    cyc(C_START); check("page1_ctrl", control_sig, 5);
    cyc(C_START); check("page0_ctrl", control_sig, 4);
    cyc(C_LOAD);  check("top_exit_ctrl", control_sig, 0);

    // mode 1 game scoring 3
    cyc(C_LOG); cyc(C_LOAD);
    cyc(C_START); check("reconf_on", timer_reconfig, 1); check("timer_on", timer_en, 1);
    check("play_ctrl", control_sig, 2);
    cyc(C_NONE);  check("reconf_off", timer_reconfig, 0);
    repeat (3) begin
      cyc(C_PWD);  check("scram", scram_pls, 1);
      cyc(C_LOAD); check("flip_a", flip_pls, 1);
      cyc(C_LOAD); check("flip_b", flip_pls, 1);
      cyc(C_CORR); cyc(C_NONE);
    end
    check("game_score", score, 3);
    cyc(C_TOUT);
    check("over_ctrl", control_sig, 3); check("over_timer", timer_en, 0);
    check("over_new_best", new_best, BEST_EN);
    check("over_best", best_score, BEST_EN ? 3 : 0);
    cyc(C_START); check("after_over_new_best", new_best, 0);

    // time_out and is_correct together
    cyc(C_LOG); cyc(C_START); solveWord();
    cyc(C_PWD); cyc(C_TOUT | C_CORR);
    check("tie_ctrl", control_sig, 3); check("tie_score", score, 1); check("tie_timer", timer_en, 0);
    cyc(C_START);

    // record best of 2 in mode 2, then a guest beats it
    cyc(C_LOG); cyc(C_LOAD); cyc(C_LOAD); cyc(C_START);
    repeat (2) solveWord();
    cyc(C_TOUT); check("m2_best", best_score, BEST_EN ? 2 : 0);
    cyc(C_START);
    guestSel = 1'b1;
    cyc(C_LOG); cyc(C_LOAD); cyc(C_LOAD); cyc(C_START);
    repeat (5) solveWord();
    check("sat_score", score, SCORE_MAX);
    cyc(C_TOUT);
    check("guest_new_best", new_best, 0); check("guest_best", best_score, BEST_EN ? 2 : 0);
    check("guest_flag", is_guest_out, 1);
    cyc(C_START);
    guestSel = 1'b0;

    // logout path
    cyc(C_LOG); cyc(C_PWD); check("logout_pulse", log_out, 1);
    cyc(C_NONE); check("logout_done", log_out, 0); check("logout_mux", mux_ctrl, 0);

    // reset mid-SWAP
    cyc(C_LOG); cyc(C_START); cyc(C_PWD);
    rst = 1'b0;
    cyc(C_LOAD); cyc(C_NONE);
    check("midrst_ctrl", control_sig, 0); check("midrst_timer", timer_en, 0);
    check("midrst_best", best_score, 0); check("midrst_mux", mux_ctrl, 0);
    rst = 1'b1;

    // randomized play
    for (int n = 0; n < 4000; n++) begin
      int r;
      r = int'($urandom_range(0, 99));
      if (r < 4)       c = C_LOG;
      else if (r < 14) c = C_PWD;
      else if (r < 19) c = C_START;
      else if (r < 45) c = C_LOAD;
      else if (r < 65) c = C_CORR;
      else if (r < 69) c = C_TOUT;
      else             c = C_NONE;
      if ($urandom_range(0, 9) == 0) c = c | (6'b000001 << $urandom_range(0, 5));
      guestSel = ($urandom_range(0, 3) == 0);
      rst = ($urandom_range(0, 399) != 0);
      cyc(c);
    end
    rst = 1'b1;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
